// File: rtl/alu_result_writeback.sv
// alu_result_writeback
//
// Return path for the SIMD ALU. Takes one 1024-bit result (16 lanes x 64 bit,
// lane i at [64i+63:64i]) per transaction and, for add/multiply ops, writes it
// to the 512-bit data memory as two words: lanes 0-7 at base, lanes 8-15 at
// base+1 (mod 2^ADDR_W). Store/load ops are consumed without a memory write.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready result handshake (in_ready is combinational)
//   in_op             00 store, 01 load, 10 add, 11 multiply
//   in_data, in_addr  1024-bit result and destination base word address
//   mem_valid/ready   memory write handshake (registered request side)
//   mem_addr, wdata   registered write address and data
//   busy              state is not idle
//   result_count      number of fully written results, wraps at 2^CNT_W

module alu_result_writeback #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1023:0]     in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [511:0]      mem_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  result_count
);

    typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

    state_e              state_q, state_d;
    // Only the upper half needs holding: the lower half goes straight into
    // the write-data register on accept.
    logic [511:0]        hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [511:0]        mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                accept;

    // A new result can enter while the final (HI) word is being taken.
    assign in_ready = (state_q == StIdle) || ((state_q == StHi) && mem_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;

        unique case (state_q)
            StLo: begin
                if (mem_ready) begin
                    state_d     = StHi;
                    mem_addr_d  = addr_q + ADDR_W'(1);
                    mem_wdata_d = hi_q;
                end
            end
            StHi: begin
                if (mem_ready) begin
                    count_d     = count_q + CNT_W'(1);
                    state_d     = StIdle;
                    mem_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Accept overrides the HI completion's return to idle.
        if (accept) begin
            hi_d   = in_data[1023:512];
            addr_d = in_addr;
            if (in_op[1]) begin
                state_d     = StLo;
                mem_valid_d = 1'b1;
                mem_addr_d  = in_addr;
                mem_wdata_d = in_data[511:0];
            end else begin
                state_d     = StIdle;
                mem_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hi_q        <= '0;
            addr_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != StIdle);
    assign result_count = count_q;

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Return path for the SIMD ALU.
- Accepts one 1024-bit ALU result per transaction: 16 lanes × 64-bit, lane i at bits [64i+63:64i].
- Splits it into two 512-bit words and writes them to the 512-bit data memory.
- Provides a valid/ready handshake on both sides and a completed-write counter for the sequencer.

Parameters:
- ADDR_W, 10, memory word address width.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  result transaction offered.
- in_ready  output  1  block can accept a transaction this cycle.
- in_op  input  2  ALU op code: 00 store, 01 load, 10 add, 11 multiply.
- in_data  input  1024  ALU output_data.
- in_addr  input  ADDR_W  destination base word address.
- mem_valid  output  1  memory write request.
- mem_ready  input  1  memory accepts the write this cycle.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  512  write data.
- busy  output  1  high whenever state is not IDLE.
- result_count  output  CNT_W  number of fully written results.

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE, mem_valid 0, mem_addr 0, mem_wdata 0, result_count 0, internal data/address registers 0.
- in_ready is combinational: high when state is IDLE, or when state is HI and mem_ready is 1.
- Accept occurs when in_valid and in_ready are both 1 at a clock edge.
- On accept, in_data, in_addr and in_op are captured into registers.
- Accepting op 00/01 (store/load):
  - No memory write is issued.
  - Next state is IDLE; result_count is unchanged.
  - The transaction is consumed in one cycle.
- Accepting op 10/11 (add/multiply): next state is LO.
- State LO:
  - mem_valid = 1, mem_addr = base, mem_wdata = captured[511:0] (lanes 0-7).
  - Remains in LO until mem_ready = 1, then goes to HI.
- State HI:
  - mem_valid = 1, mem_addr = base + 1 modulo 2^ADDR_W (base all-ones wraps to 0), mem_wdata = captured[1023:512] (lanes 8-15).
  - On mem_ready = 1, result_count increments and wraps at 2^CNT_W.
  - On that same edge, if a new accept also occurs, the new transaction is captured and next state follows its op (LO, or IDLE for 00/01).
  - With no new accept, next state is IDLE.
- Latency and throughput:
  - The first write is presented in the cycle after accept.
  - Minimum two cycles per add/multiply result; sustained throughput is one result per 2 cycles with mem_ready tied high.
- mem_valid, mem_addr and mem_wdata are registered outputs.
- Output stability: once mem_valid = 1, mem_addr and mem_wdata hold stable until mem_ready.
- Data handling:
  - Lane data is written exactly as received; no re-saturation or sign manipulation.
  - Bits above bit 32 of add lanes are passed through unchanged.
- in_valid while in_ready = 0: ignored; the upstream stage must hold its transaction.
- Reset mid-transfer: any pending write is abandoned and no partial count is recorded. On release, state is IDLE and in_ready is 1.
- busy = (state != IDLE).

Test Plan:
- Single multiply: in_op = 11, in_addr = 0x010, in_data lane i = i+1, mem_ready = 1.
  - Required: mem write {0x010, lanes 0-7} then {0x011, lanes 8-15} on consecutive cycles; result_count = 1; in_ready = 1 on the cycle after the HI write.
- Back-pressure: same transaction with mem_ready low for 3 cycles in LO and 2 cycles in HI.
  - Required: mem_addr/mem_wdata stable while stalled; exactly 2 accepted writes; in_ready = 0 throughout LO.
- Back-to-back: two add results at 0x020 and 0x040 with in_valid held high.
  - Required: the second accept coincides with the HI write of the first; write addresses 0x020, 0x021, 0x040, 0x041 with no idle cycle between; result_count = 2.
- Non-writing ops: in_op = 00, then 01.
  - Required: each accepted in one cycle; mem_valid stays 0; result_count unchanged.
- Address wrap: ADDR_W = 10, in_addr = 0x3FF, op 10.
  - Required: writes go to 0x3FF then 0x000.
- Reset mid-operation: assert rst_n low while in HI with mem_ready = 0.
  - Required: mem_valid drops to 0 immediately (asynchronous); result_count = 0; after release, in_ready = 1 and busy = 0.
